// File: rtl/axi_sram_slave_pkg.sv
// axi_sram_slave_pkg: AXI burst/response codes, FSM encodings and address helpers
package axi_sram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'd2;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_BURST = 2'd1} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

    // True when the byte address lies beyond the word-addressed memory.
    function automatic logic addr_oor(input logic [31:0] addr, input int idx_w);
        return (addr >> (idx_w + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/axi_addr_next.sv
// axi_addr_next: next beat address for FIXED/INCR bursts plus unsupported-burst flag
module axi_addr_next
    import axi_sram_slave_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] addr_next,
    output logic        err
);

    always_comb begin
        addr_next = burst == BURST_INCR ? addr + (32'd1 << size) : addr;
        err = burst == BURST_WRAP || burst == BURST_RSVD || size > SIZE_4B;
    end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave with independent read/write engines over a byte-enabled word memory
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    logic [31:0] mem [MEM_WORDS];

    r_state_e    r_state, r_next;
    w_state_e    w_state, w_next;
    logic [31:0] r_addr, r_nxt, r_ld_addr, w_addr, w_nxt;
    logic [3:0]  r_len, r_beat, w_len, w_beat;
    logic [2:0]  r_size, w_size;
    logic [1:0]  r_burst, w_burst;
    logic        r_bad, rn_err, r_end, r_ld, r_ld_err;
    logic        w_bad, w_err, wn_err, w_end, w_beat_err, w_fin_err;
    logic        ar_hs, r_hs, aw_hs, w_hs;
    logic        unused;

    assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    assign arready = r_state == R_IDLE && !rst;
    assign rvalid  = r_state == R_BURST;
    assign rlast   = rvalid && r_end;
    assign awready = w_state == W_IDLE && !rst;
    assign wready  = w_state == W_DATA && !rst;
    assign bvalid  = w_state == W_RESP;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign r_end = r_beat == r_len;
    assign w_end = w_beat == w_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_comb begin
        r_next = r_state;
        w_next = w_state;
        if (r_state == R_IDLE && arvalid) r_next = R_BURST;
        if (r_state == R_BURST && rready && r_end) r_next = R_IDLE;
        if (w_state == W_IDLE && awvalid) w_next = W_DATA;
        if (w_state == W_DATA && wvalid && w_end) w_next = W_RESP;
        if (w_state == W_RESP && bready) w_next = W_IDLE;
    end

    axi_addr_next u_rnext (
        .addr      (r_state == R_IDLE ? araddr : r_addr),
        .size      (r_state == R_IDLE ? arsize : r_size),
        .burst     (r_state == R_IDLE ? arburst : r_burst),
        .addr_next (r_nxt),
        .err       (rn_err)
    );

    // rdata is prefetched for the next beat on every handshake, so it only moves on acceptance.
    assign r_ld      = ar_hs || (r_hs && !r_end);
    assign r_ld_addr = ar_hs ? araddr : r_nxt;
    assign r_ld_err  = ar_hs ? (rn_err || |arlen[7:4] || addr_oor(araddr, IDX_W))
                             : (r_bad || addr_oor(r_nxt, IDX_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid     <= arid;
                r_addr  <= araddr;
                r_len   <= arlen[3:0];
                r_size  <= arsize;
                r_burst <= arburst;
                r_bad   <= rn_err || |arlen[7:4];
                r_beat  <= '0;
            end else if (r_hs) begin
                r_addr <= r_nxt;
                r_beat <= r_beat + 4'd1;
            end
            if (r_ld) begin
                rdata <= r_ld_err ? 32'd0 : mem[r_ld_addr[IDX_W+1:2]];
                rresp <= r_ld_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    axi_addr_next u_wnext (
        .addr      (w_state == W_IDLE ? awaddr : w_addr),
        .size      (w_state == W_IDLE ? awsize : w_size),
        .burst     (w_state == W_IDLE ? awburst : w_burst),
        .addr_next (w_nxt),
        .err       (wn_err)
    );

    // A wlast that disagrees with the beat count is reported, but the burst length is trusted.
    assign w_beat_err = w_bad || addr_oor(w_addr, IDX_W);
    assign w_fin_err  = w_err || w_beat_err || (wlast != w_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            bid     <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen[3:0];
            w_size  <= awsize;
            w_burst <= awburst;
            w_bad   <= wn_err || |awlen[7:4];
            w_err   <= 1'b0;
            w_beat  <= '0;
        end else if (w_hs) begin
            w_addr <= w_nxt;
            w_beat <= w_beat + 4'd1;
            w_err  <= w_fin_err;
            if (w_end) bresp <= w_fin_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !w_beat_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_addr[IDX_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
